// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO behind a UART receiver.
//
// Converts the receiver's level-style data-valid (rx_ready) into a single
// push per assertion, buffers bytes in a DEPTH-entry circular memory and
// presents the oldest byte first-word-fall-through on rd_data.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   rx_data    in   [WIDTH]  received byte
//   rx_ready   in   receiver data-valid level
//   rd_en      in   consumer pop request (ignored while empty)
//   rd_data    out  [WIDTH]  head byte, valid whenever empty==0
//   empty      out  count == 0
//   full       out  count == DEPTH
//   count      out  [log2(DEPTH)+1]  occupancy
//   overflow   out  sticky: a byte arrived while full with no pop
//   clear_ovf  in   synchronous clear of overflow (a coinciding set wins)
//
// Configuration macro: UART_RX_FIFO_OVERWRITE_EN
//   defined   -> a byte arriving while full replaces the oldest entry
//   undefined -> a byte arriving while full is dropped (default)
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_ready,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rx_ready_q;

  logic wr_ev;    // rising edge of rx_ready
  logic pop;      // accepted read
  logic push;     // write that grows or keeps occupancy
  logic ovf_ev;   // write arriving while full with no pop
  logic mem_we;   // memory write strobe
  logic rd_adv;   // read pointer advance

  // Status and FWFT head are decoded straight from the registered state.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

  assign wr_ev  = rx_ready & ~rx_ready_q;
  assign pop    = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push   = wr_ev & (~full | pop);
  assign ovf_ev = wr_ev & full & ~pop;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  // Overwrite: store at the tail and drop the oldest by advancing the head.
  assign mem_we = push | ovf_ev;
  assign rd_adv = pop | ovf_ev;
`else
  // Drop: the incoming byte is discarded, pointers stay put.
  assign mem_we = push;
  assign rd_adv = pop;
`endif

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers, occupancy, edge detector and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_ready_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;

      if (mem_we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      if (ovf_ev) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo.
// The driver applies stimulus on the falling edge and advances a queue-based
// reference model; expected visible state and expected popped bytes are
// queued. The monitor samples shortly after each falling edge and compares.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             overflow;
  logic             clear_ovf;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clear_ovf(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    int head;
  } st_t;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Reference model: plain byte queue plus previous rx_ready level.
  int  mq[$];
  bit  movf;
  bit  mprev;
  st_t st_q[$];
  int  dq[$];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_state();
    st_t s;
    s.cnt  = mq.size();
    s.ovf  = movf;
    s.head = (mq.size() != 0) ? mq[0] : 0;
    st_q.push_back(s);
  endtask

  task automatic model_reset();
    mq.delete();
    dq.delete();
    st_q.delete();
    movf  = 1'b0;
    mprev = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input int d, input bit rd, input bit clr);
    bit ev;
    bit set;
    ev    = rdy && !mprev;
    mprev = rdy;
    set   = 1'b0;
    if (rd && mq.size() != 0) begin
      dq.push_back(mq.pop_front());
    end
    if (ev) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(d);
      end else begin
        set = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
        void'(mq.pop_front());
        mq.push_back(d);
`endif
      end
    end
    if (set) movf = 1'b1;
    else if (clr) movf = 1'b0;
    push_state();
  endtask

  task automatic cyc(input bit rdy, input int d, input bit rd, input bit clr);
    @(negedge clk);
    rx_ready  = rdy;
    rx_data   = WIDTH'(d);
    rd_en     = rd;
    clear_ovf = clr;
    model_step(rdy, d, rd, clr);
  endtask

  task automatic push_byte(input int d);
    cyc(1'b1, d, 1'b0, 1'b0);
    cyc(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) push_byte(i);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b0);
  endtask

  // Monitor: compare visible state and popped bytes against the queues.
  always begin
    st_t s;
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (st_q.size() == 0) begin
        check("state_queue_nonempty", 0, 1);
      end else begin
        s = st_q.pop_front();
        check("count", int'(count), s.cnt);
        check("empty", int'(empty), int'(s.cnt == 0));
        check("full", int'(full), int'(s.cnt == DEPTH));
        check("overflow", int'(overflow), int'(s.ovf));
        if (s.cnt != 0) check("rd_data_head", int'(rd_data), s.head);
      end
      if (rd_en && !empty) begin
        if (dq.size() == 0) check("unexpected_pop", 1, 0);
        else check("pop_data", int'(rd_data), dq.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b0;
    rx_data   = 8'h3C;
    rx_ready  = 1'b1;   // already high when reset releases
    rd_en     = 1'b0;
    clear_ovf = 1'b0;
    #12;
    check("reset_empty", int'(empty), 1);
    check("reset_count", int'(count), 0);
    #15;                // release between a rising and a falling edge
    reset = 1'b1;
    model_reset();
    push_state();
    mon_en = 1'b1;

    // rx_ready high across reset release pushes on the first edge
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    drain(2);

    // single pulse, then single pop
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // held level gives exactly one entry
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    drain(2);

    // fill and drain twice for pointer wrap
    for (int r = 0; r < 2; r++) begin
      fill_seq();
      drain(17);
    end

    // overflow while full with no pop
    fill_seq();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    drain(17);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // push with pop while full, then set coinciding with clear
    fill_seq();
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    drain(17);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      if (((i / 200) % 2) == 0) rd = ($urandom % 4) == 0;
      else rd = ($urandom % 4) != 0;
      cyc(1'($urandom % 2), int'($urandom % 256), rd, ($urandom % 16) == 0);
    end
    drain(17);
    cyc(1'b0, 0, 1'b0, 1'b1);

    // reach count 5 with overflow set, then asynchronous reset between edges
    fill_seq();
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    drain(11);
    cyc(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    check("leftover_pops", dq.size(), 0);
    mon_en = 1'b0;
    check("pre_reset_count", int'(count), 5);
    check("pre_reset_overflow", int'(overflow), 1);
    reset = 1'b0;
    #1;
    check("async_reset_empty", int'(empty), 1);
    check("async_reset_count", int'(count), 0);
    check("async_reset_overflow", int'(overflow), 0);
    check("async_reset_full", int'(full), 0);
    #1;
    reset = 1'b1;
    model_reset();
    push_state();
    mon_en = 1'b1;

    // stored bytes are gone: pop while empty is ignored, new data flows
    cyc(1'b0, 0, 1'b1, 1'b0);
    push_byte(8'h5A);
    drain(2);
    cyc(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    check("final_pop_queue", dq.size(), 0);
    check("final_state_queue", st_q.size(), 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
